// File: rtl/gate_response_misr.sv
`default_nettype none
// ============================================================================
// Module   : gate_response_misr
// Purpose  : Multiple-input signature register that compacts the response
//            vectors of a gate-netlist stage into a signature. A run starts on
//            a start pulse, absorbs NUM_VEC accepted beats, then compares the
//            final signature against a golden value and reports pass.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   single clock, rising-edge
//   rst          in   asynchronous active-high reset
//   start        in   one-cycle request to begin a run (IDLE/DONE only)
//   abort        in   cancel the current run (RUN only)
//   resp_valid   in   upstream response beat valid
//   resp_data    in   RESP_W netlist outputs, LSB first:
//                     N504,N505,N509,N510,N512,N513,N514,N515,N516,N517
//   resp_ready   out  block accepts a beat (high only in RUN)
//   expected_sig in   golden signature, sampled on the final beat
//   signature    out  current MISR contents
//   beat_cnt     out  beats accepted in this run
//   busy         out  high in RUN
//   done         out  high in DONE
//   pass         out  final signature matched expected_sig
// ============================================================================
module gate_response_misr #(
    parameter int               RESP_W  = 10,
    parameter int               SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = 16'h1021,
    parameter logic [SIG_W-1:0] SEED    = 16'h0000,
    parameter int               NUM_VEC = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_data,
    output logic              resp_ready,
    input  logic [SIG_W-1:0]  expected_sig,
    output logic [SIG_W-1:0]  signature,
    output logic [15:0]       beat_cnt,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] c_num_vec = 16'(NUM_VEC);

    state_t             state_q;
    logic [SIG_W-1:0]   signature_q;
    logic [15:0]        beat_cnt_q;
    logic               pass_q;
    logic               busy_q;
    logic               done_q;
    logic               ready_q;

    logic [SIG_W-1:0]   signature_d;
    logic [15:0]        beat_cnt_d;
    logic [SIG_W-1:0]   w_resp_ext;
    logic               w_last_beat;

    // Response is narrower than the signature; upper bits are zero-filled.
    assign w_resp_ext = SIG_W'(resp_data);

    // MISR step: shift left, fold the outgoing MSB back through the
    // polynomial taps, then mix in the parallel response word.
    always_comb begin
        signature_d = {signature_q[SIG_W-2:0], 1'b0}
                    ^ (signature_q[SIG_W-1] ? POLY : '0)
                    ^ w_resp_ext;
        beat_cnt_d  = beat_cnt_q + 16'd1;
    end

    // NUM_VEC is at most 65535, so the incremented count never wraps
    // before the run terminates.
    assign w_last_beat = (beat_cnt_d == c_num_vec);

    // Single-process FSM; all status outputs are registered so resp_ready
    // depends only on state, never on resp_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            signature_q <= SEED;
            beat_cnt_q  <= 16'd0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // Start outranks abort here; abort is meaningless
                    // outside a run. DONE holds its results until start.
                    if (start) begin
                        state_q     <= ST_RUN;
                        signature_q <= SEED;
                        beat_cnt_q  <= 16'd0;
                        pass_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        ready_q     <= 1'b1;
                    end
                end

                ST_RUN: begin
                    // Start is ignored during a run. Abort wins over any
                    // beat presented in the same cycle; signature and count
                    // are left as they were for post-mortem inspection.
                    if (abort) begin
                        state_q <= ST_IDLE;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b0;
                    end else if (resp_valid) begin
                        signature_q <= signature_d;
                        beat_cnt_q  <= beat_cnt_d;
                        if (w_last_beat) begin
                            state_q <= ST_DONE;
                            pass_q  <= (signature_d == expected_sig);
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    pass_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign resp_ready = ready_q;
    assign signature  = signature_q;
    assign beat_cnt   = beat_cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_response_misr.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_response_misr
// Purpose  : Directed self-checking bench for gate_response_misr. Three
//            instances share the response bus, abort and golden signature;
//            each has its own start so only one runs at a time:
//              u_dut_a  SEED=0x0000 NUM_VEC=2  (two-beat hand-computed run)
//              u_dut_b  SEED=0x8000 NUM_VEC=1  (feedback path, failing run)
//              u_dut_c  SEED=0x0000 NUM_VEC=6  (gaps, abort, reset, restart)
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_response_misr;

    localparam int c_nv_c = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b, start_c;
    logic        abort;
    logic        resp_valid;
    logic [9:0]  resp_data;
    logic [15:0] expected_sig;

    logic        ready_a, busy_a, done_a, pass_a;
    logic [15:0] sig_a, cnt_a;
    logic        ready_b, busy_b, done_b, pass_b;
    logic [15:0] sig_b, cnt_b;
    logic        ready_c, busy_c, done_c, pass_c;
    logic [15:0] sig_c, cnt_c;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] m_sig;
    int          m_cnt;

    logic [9:0] tbl [0:9] = '{10'h155, 10'h2AA, 10'h3FF, 10'h001, 10'h0F0,
                              10'h30C, 10'h1E1, 10'h200, 10'h07F, 10'h333};
    // Valid pattern for the gap test, bit i = cycle i: 1,0,0,1,1,0,1,0,1,1
    logic [9:0] vpat = 10'b1101011001;

    always #5 clk = ~clk;

    gate_response_misr #(.SEED(16'h0000), .NUM_VEC(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(ready_a),
        .expected_sig(expected_sig), .signature(sig_a), .beat_cnt(cnt_a),
        .busy(busy_a), .done(done_a), .pass(pass_a)
    );

    gate_response_misr #(.SEED(16'h8000), .NUM_VEC(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(ready_b),
        .expected_sig(expected_sig), .signature(sig_b), .beat_cnt(cnt_b),
        .busy(busy_b), .done(done_b), .pass(pass_b)
    );

    gate_response_misr #(.SEED(16'h0000), .NUM_VEC(c_nv_c)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(ready_c),
        .expected_sig(expected_sig), .signature(sig_c), .beat_cnt(cnt_c),
        .busy(busy_c), .done(done_c), .pass(pass_c)
    );

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference MISR step for the default 16-bit signature / 0x1021 taps.
    function automatic logic [15:0] misr(input logic [15:0] s, input logic [9:0] d);
        misr = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {6'b0, d};
    endfunction

    // One cycle on instance C; acc says whether the model expects acceptance.
    task automatic c_beat(input logic v, input logic [9:0] d, input logic acc);
        resp_valid = v;
        resp_data  = d;
        @(negedge clk);
        if (v && acc) begin
            m_sig = misr(m_sig, d);
            m_cnt++;
        end
        check_val("c_cnt", cnt_c, 32'(m_cnt));
        check_val("c_sig", sig_c, 32'(m_sig));
        resp_valid = 1'b0;
    endtask

    task automatic start_run_c();
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        m_sig = 16'h0000;
        m_cnt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_c;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        abort = 1'b0; resp_valid = 1'b0; resp_data = '0; expected_sig = '0;
        m_sig = 16'h0000; m_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ---- reset state ----
        check_val("rst_sig_c",   sig_c,   32'h0);
        check_val("rst_cnt_c",   cnt_c,   32'h0);
        check_val("rst_busy_c",  busy_c,  32'h0);
        check_val("rst_done_c",  done_c,  32'h0);
        check_val("rst_pass_c",  pass_c,  32'h0);
        check_val("rst_ready_c", ready_c, 32'h0);
        check_val("rst_sig_b",   sig_b,   32'h8000);

        // ---- A: two beats 0x3FF, 0x001 -> 0x03FF, 0x07FF, pass ----
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_val("a_busy",  busy_a,  32'h1);
        check_val("a_ready", ready_a, 32'h1);
        check_val("a_seed",  sig_a,   32'h0);
        expected_sig = 16'h07FF;
        resp_valid = 1'b1; resp_data = 10'h3FF;
        @(negedge clk);
        check_val("a_sig1", sig_a, 32'h03FF);
        check_val("a_cnt1", cnt_a, 32'h1);
        resp_data = 10'h001;
        @(negedge clk);
        resp_valid = 1'b0;
        check_val("a_sig2",  sig_a,   32'h07FF);
        check_val("a_cnt2",  cnt_a,   32'h2);
        check_val("a_done",  done_a,  32'h1);
        check_val("a_pass",  pass_a,  32'h1);
        check_val("a_busy0", busy_a,  32'h0);
        check_val("a_rdy0",  ready_a, 32'h0);

        // ---- B: seed 0x8000, beat 0 -> 0x1021 via feedback, expected 0x1020 ----
        expected_sig = 16'h1020;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        resp_valid = 1'b1; resp_data = 10'h000;
        @(negedge clk);
        resp_valid = 1'b0;
        check_val("b_sig",  sig_b,  32'h1021);
        check_val("b_cnt",  cnt_b,  32'h1);
        check_val("b_done", done_b, 32'h1);
        check_val("b_pass", pass_b, 32'h0);
        // A sat in DONE while that beat went by
        check_val("a_hold_sig",  sig_a,  32'h07FF);
        check_val("a_hold_cnt",  cnt_a,  32'h2);
        check_val("a_hold_pass", pass_a, 32'h1);

        // ---- C: valid gaps, compare against model ----
        exp_c = 16'h0000;
        for (int i = 0; i < 10; i++)
            if (vpat[i]) exp_c = misr(exp_c, tbl[i]);
        expected_sig = exp_c;
        start_run_c();
        for (int i = 0; i < 10; i++)
            c_beat(vpat[i], tbl[i], 1'b1);
        check_val("c_gap_done", done_c, 32'h1);
        check_val("c_gap_pass", pass_c, 32'h1);
        c_beat(1'b1, 10'h3C3, 1'b0);        // held in DONE
        check_val("c_gap_pass_hold", pass_c, 32'h1);

        // ---- C: start in DONE restarts cleanly ----
        start_run_c();
        check_val("c_rs_sig",  sig_c,   32'h0);
        check_val("c_rs_cnt",  cnt_c,   32'h0);
        check_val("c_rs_busy", busy_c,  32'h1);
        check_val("c_rs_done", done_c,  32'h0);
        check_val("c_rs_pass", pass_c,  32'h0);

        // ---- C: start during RUN ignored, abort with beat at cnt=5 ----
        c_beat(1'b1, tbl[0], 1'b1);
        c_beat(1'b1, tbl[1], 1'b1);
        start_c = 1'b1;
        c_beat(1'b1, tbl[2], 1'b1);        // count must reach 3, not restart
        start_c = 1'b0;
        c_beat(1'b1, tbl[3], 1'b1);
        c_beat(1'b1, tbl[4], 1'b1);
        abort = 1'b1;
        c_beat(1'b1, tbl[5], 1'b0);        // beat discarded, cnt stays 5
        abort = 1'b0;
        check_val("c_ab_cnt5",  cnt_c,   32'h5);
        check_val("c_ab_busy",  busy_c,  32'h0);
        check_val("c_ab_ready", ready_c, 32'h0);
        check_val("c_ab_pass",  pass_c,  32'h0);
        check_val("c_ab_done",  done_c,  32'h0);
        c_beat(1'b1, tbl[6], 1'b0);        // IDLE accepts nothing

        // ---- C: asynchronous reset mid-run ----
        start_run_c();
        c_beat(1'b1, tbl[6], 1'b1);
        c_beat(1'b1, tbl[7], 1'b1);
        #2 rst = 1'b1;
        #1;
        check_val("ar_sig_c",   sig_c,   32'h0);
        check_val("ar_cnt_c",   cnt_c,   32'h0);
        check_val("ar_busy_c",  busy_c,  32'h0);
        check_val("ar_ready_c", ready_c, 32'h0);
        check_val("ar_done_c",  done_c,  32'h0);
        check_val("ar_pass_c",  pass_c,  32'h0);
        check_val("ar_done_a",  done_a,  32'h0);
        check_val("ar_sig_b",   sig_b,   32'h8000);
        @(negedge clk);
        rst = 1'b0;
        m_sig = 16'h0000; m_cnt = 0;
        c_beat(1'b1, tbl[8], 1'b0);
        check_val("ar_idle_rdy", ready_c, 32'h0);

        // ---- C: clean run after reset ----
        exp_c = 16'h0000;
        for (int i = 0; i < c_nv_c; i++) exp_c = misr(exp_c, tbl[i+4]);
        expected_sig = exp_c;
        start_run_c();
        for (int i = 0; i < c_nv_c; i++) c_beat(1'b1, tbl[i+4], 1'b1);
        check_val("c_clean_done", done_c, 32'h1);
        check_val("c_clean_pass", pass_c, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
